// File: rtl/ram_pkg.sv
// Shared types, default widths and the byte-merge helper for the dual-port RAM.
package ram_pkg;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } ram_state_t;

   localparam int RAM_DATA_W = 32'sd32;
   localparam int RAM_ADDR_W = 32'sd15;

   // Widest word the merge helper handles; callers zero-extend and truncate.
   localparam int RAM_MAX_W  = 32'sd256;

   typedef logic [RAM_MAX_W-1:0]       ram_word_t;
   typedef logic [RAM_MAX_W/8-1:0]     ram_be_t;

   // Byte-wise merge: byte i comes from new_word where be[i] is set, else from old_word.
   function automatic ram_word_t be_merge(input ram_word_t old_word,
                                          input ram_word_t new_word,
                                          input ram_be_t   be);
      ram_word_t merged;
      for (int i = 0; i < RAM_MAX_W / 8; i++) begin
         merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/ram_bank.sv
// Storage array with one byte-enabled write port and two read ports. The read
// ports are sampled by the output registers in the top level, which makes each
// port a one-cycle synchronous read.
module ram_bank
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = RAM_DATA_W,
   parameter int ADDR_WIDTH = RAM_ADDR_W,
   parameter int DEPTH      = 32'sd1 << ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic [ADDR_WIDTH-1:0]   d_raddr,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   input  logic [ADDR_WIDTH-1:0]   f_raddr,
   output logic [DATA_WIDTH-1:0]   f_rdata
);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   // Byte-enabled write; the array itself carries no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= DATA_WIDTH'(be_merge(ram_word_t'(mem[waddr]),
                                            ram_word_t'(wdata),
                                            ram_be_t'(wbe)));
      end
   end

   assign d_rdata = mem[d_raddr];
   assign f_rdata = mem[f_raddr];

endmodule

// File: rtl/ram_dual_port.sv
// Dual-port program/data memory: data port (read/write, byte enables, range
// error) and read-only fetch port, with an optional zero-fill after reset.
module ram_dual_port
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH     = RAM_DATA_W,
   parameter int ADDR_WIDTH     = RAM_ADDR_W,
   parameter int DEPTH          = 32'sd1 << ADDR_WIDTH,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   output logic                    d_ready,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_err,
   input  logic                    f_req,
   input  logic [ADDR_WIDTH-1:0]   f_addr,
   output logic                    f_ready,
   output logic                    f_rvalid,
   output logic [DATA_WIDTH-1:0]   f_rdata,
   output logic                    init_done
);

   localparam int                  BE_W    = DATA_WIDTH / 32'sd8;
   // One extra bit so DEPTH = 2**ADDR_WIDTH is representable in the range check.
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(DEPTH - 32'sd1);

   ram_state_t              state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0]   clr_cnt_r, clr_cnt_nxt_s;
   logic                    ready_r;

   logic                    d_acc_s, f_acc_s;
   logic                    d_in_range_s, f_in_range_s, collide_s;

   logic                    bank_we_s;
   logic [ADDR_WIDTH-1:0]   bank_waddr_s;
   logic [DATA_WIDTH-1:0]   bank_wdata_s;
   logic [BE_W-1:0]         bank_wbe_s;
   logic [DATA_WIDTH-1:0]   bank_d_rdata_s, bank_f_rdata_s, f_word_s;

   logic                    d_rvalid_r, d_err_r, f_rvalid_r;
   logic [DATA_WIDTH-1:0]   d_rdata_r, f_rdata_r;

   assign d_acc_s      = d_req & ready_r;
   assign f_acc_s      = f_req & ready_r;
   assign d_in_range_s = ({1'b0, d_addr} < DEPTH_W);
   assign f_in_range_s = ({1'b0, f_addr} < DEPTH_W);
   assign collide_s    = f_acc_s & d_acc_s & d_we & d_in_range_s & (f_addr == d_addr);

   // Next state and clear counter: INIT sweeps every word (or passes straight through).
   always_comb begin
      state_nxt_s   = state_r;
      clr_cnt_nxt_s = clr_cnt_r;
      case (state_r)
         INIT: begin
            if (CLEAR_ON_RESET) begin
               clr_cnt_nxt_s = clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
               if (clr_cnt_r == LAST_W) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = INIT;
               end
            end else begin
               state_nxt_s = RUN;
            end
         end
         RUN:     state_nxt_s = RUN;
         default: state_nxt_s = INIT;
      endcase
   end

   // State, clear counter and the shared ready flag (high only in RUN).
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r   <= INIT;
         clr_cnt_r <= {ADDR_WIDTH{1'b0}};
         ready_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         clr_cnt_r <= clr_cnt_nxt_s;
         ready_r   <= (state_nxt_s == RUN);
      end
   end

   // Write port source: zero-fill during INIT, in-range data writes in RUN, nothing in reset.
   always_comb begin
      bank_we_s    = 1'b0;
      bank_waddr_s = d_addr;
      bank_wdata_s = d_wdata;
      bank_wbe_s   = d_be;
      if (!reset_n) begin
         bank_we_s = 1'b0;
      end else if (state_r == INIT) begin
         if (CLEAR_ON_RESET) begin
            bank_we_s    = 1'b1;
            bank_waddr_s = clr_cnt_r;
            bank_wdata_s = {DATA_WIDTH{1'b0}};
            bank_wbe_s   = {BE_W{1'b1}};
         end else begin
            bank_we_s = 1'b0;
         end
      end else if (d_acc_s && d_we && d_in_range_s) begin
         bank_we_s = 1'b1;
      end else begin
         bank_we_s = 1'b0;
      end
   end

   // Write-first collision: fetch sees the word as it will be after this write.
   always_comb begin
      if (collide_s) begin
         f_word_s = DATA_WIDTH'(be_merge(ram_word_t'(bank_f_rdata_s),
                                         ram_word_t'(d_wdata),
                                         ram_be_t'(d_be)));
      end else begin
         f_word_s = bank_f_rdata_s;
      end
   end

   // Output registers: strobes for one cycle, read data held until the next read.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         d_rvalid_r <= 1'b0;
         d_err_r    <= 1'b0;
         f_rvalid_r <= 1'b0;
         d_rdata_r  <= {DATA_WIDTH{1'b0}};
         f_rdata_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         d_rvalid_r <= d_acc_s & ~d_we;
         d_err_r    <= d_acc_s & ~d_in_range_s;
         f_rvalid_r <= f_acc_s;
         if (d_acc_s && !d_we) begin
            d_rdata_r <= d_in_range_s ? bank_d_rdata_s : {DATA_WIDTH{1'b0}};
         end else begin
            d_rdata_r <= d_rdata_r;
         end
         if (f_acc_s) begin
            f_rdata_r <= f_in_range_s ? f_word_s : {DATA_WIDTH{1'b0}};
         end else begin
            f_rdata_r <= f_rdata_r;
         end
      end
   end

   assign d_ready   = ready_r;
   assign f_ready   = ready_r;
   assign init_done = ready_r;
   assign d_rvalid  = d_rvalid_r;
   assign d_err     = d_err_r;
   assign d_rdata   = d_rdata_r;
   assign f_rvalid  = f_rvalid_r;
   assign f_rdata   = f_rdata_r;

   ram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_bank (
      .clk     (clk),
      .we      (bank_we_s),
      .waddr   (bank_waddr_s),
      .wdata   (bank_wdata_s),
      .wbe     (bank_wbe_s),
      .d_raddr (d_addr),
      .d_rdata (bank_d_rdata_s),
      .f_raddr (f_addr),
      .f_rdata (bank_f_rdata_s)
   );

endmodule
